pixel_stream: RTL and testbench

Streaming driver for a chain of WS2812-style single-wire LEDs. It pulls one pixel word per LED from a valid/ready stream and applies a global brightness scale. It serialises each pixel MSB-first as fixed-period pulse-width bits, then holds the line low for the latch pause. It sits between the frame/pattern generator and the LED data pin. It supersedes the fixed 24-bit single-colour driver and adds a start/done frame handshake, per-LED colour, RGBW mode, brightness and underrun detection.

---
 rtl/pixel_pkg.sv | 44 ++++
 rtl/pixel_bit_timer.sv | 64 ++++++
 rtl/pixel_stream.sv | 195 +++++++++++++++++++
 tb/tb_pixel_stream.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
//==============================================================================
// Module      : pixel_pkg
// Description : Shared types, pixel channel layout and helpers for pixel_stream.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package pixel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_TXFER = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    localparam int c_G_LSB = 24;
    localparam int c_R_LSB = 16;
    localparam int c_B_LSB = 8;
    localparam int c_W_LSB = 0;

    // Counter must hold 0..max-1 for the longer of the bit period and the pause.
    function automatic int tick_width(input int data_ticks, input int pause_ticks);
        int m;
        m = (data_ticks > pause_ticks) ? data_ticks : pause_ticks;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] bright);
        logic [15:0] p;
        p = {8'd0, c} * ({8'd0, bright} + 16'd1);
        return p[15:8];
    endfunction

    function automatic logic [31:0] scale_word(input logic [31:0] w, input logic [7:0] bright);
        return {scale_chan(w[c_G_LSB +: 8], bright),
                scale_chan(w[c_R_LSB +: 8], bright),
                scale_chan(w[c_B_LSB +: 8], bright),
                scale_chan(w[c_W_LSB +: 8], bright)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_bit_timer.sv
//==============================================================================
// Module      : pixel_bit_timer
// Description : Bit-period / pause tick counter with registered pulse-width output.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pixel_bit_timer #(
    parameter int DATA_TICKS = 25,
    parameter int T0H        = 6,
    parameter int T1H        = 12,
    parameter int TW         = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_pause,
    input  logic          i_bit,
    output logic [TW-1:0] o_tick,
    output logic          o_out,
    output logic          o_last
);

    logic          r_run;
    logic          r_pause;
    logic [TW-1:0] r_tick;
    logic          r_out;
    logic [TW-1:0] w_tick_nxt;
    logic          w_last;

    assign w_last = r_run && (r_tick == TW'(DATA_TICKS - 1));

    // i_en / i_pause / i_bit describe the coming cycle, so the line level is
    // registered against the tick it will be shown with.
    always_comb begin
        w_tick_nxt = '0;
        if (i_en) begin
            w_tick_nxt = (r_run && !w_last) ? r_tick + TW'(1) : '0;
        end else if (i_pause) begin
            w_tick_nxt = r_pause ? r_tick + TW'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run   <= 1'b0;
            r_pause <= 1'b0;
            r_tick  <= '0;
            r_out   <= 1'b0;
        end else begin
            r_run   <= i_en;
            r_pause <= i_pause && !i_en;
            r_tick  <= w_tick_nxt;
            r_out   <= i_en && (w_tick_nxt < (i_bit ? TW'(T1H) : TW'(T0H)));
        end
    end

    assign o_tick = r_tick;
    assign o_out  = r_out;
    assign o_last = w_last;

endmodule

`default_nettype wire

// File: rtl/pixel_stream.sv
//==============================================================================
// Module      : pixel_stream
// Description : WS2812-style LED chain driver with prefetch, brightness and underrun.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pixel_stream
    import pixel_pkg::*;
#(
    parameter int DATA_TICKS  = 25,
    parameter int T0H         = 6,
    parameter int T1H         = 12,
    parameter int PAUSE_TICKS = 1600,
    parameter int LEDS        = 8,
    parameter int WHITE       = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  bright,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [31:0] pix_data,
    output logic        busy,
    output logic        done,
    output logic        underrun,
    output logic        out
);

    localparam int c_BITS = 24 + 8 * WHITE;
    localparam int c_TW   = tick_width(DATA_TICKS, PAUSE_TICKS);
    localparam int c_LW   = $clog2(LEDS + 1);

    state_t          r_state;
    logic [7:0]      r_bright;
    logic [31:0]     r_shift;
    logic [31:0]     r_pf;
    logic            r_pf_full;
    logic [5:0]      r_bit;
    logic [c_LW-1:0] r_acc;
    logic [c_LW-1:0] r_led;
    logic            r_abort;
    logic            r_underrun;

    logic [c_TW-1:0] w_tick;
    logic            w_out;
    logic            w_last;
    logic            w_acc;
    logic [31:0]     w_scaled;
    logic            w_end_led;
    logic            w_more;
    logic            w_next_avail;
    logic [31:0]     w_next_word;
    logic            w_pause_last;
    logic            w_tx_nxt;
    logic            w_pz_nxt;
    logic            w_bit_nxt;

    assign pix_ready = (r_state == ST_LOAD) ||
                       ((r_state == ST_TXFER) && !r_pf_full && (r_acc < c_LW'(LEDS)));
    assign w_acc        = pix_ready && pix_valid;
    assign w_scaled     = scale_word(pix_data, r_bright);
    assign w_end_led    = w_last && (r_bit == 6'(c_BITS - 1));
    assign w_more       = (r_led != c_LW'(LEDS - 1));
    // A pixel arriving exactly on the LED boundary bypasses the prefetch.
    assign w_next_avail = r_pf_full || w_acc;
    assign w_next_word  = r_pf_full ? r_pf : w_scaled;
    assign w_pause_last = (r_state == ST_PAUSE) && (w_tick == c_TW'(PAUSE_TICKS - 1));

    // What the line does next cycle, handed to the timer ahead of time.
    always_comb begin
        w_tx_nxt  = 1'b0;
        w_pz_nxt  = 1'b0;
        w_bit_nxt = 1'b0;
        case (r_state)
            ST_LOAD: begin
                if (w_acc) begin
                    w_tx_nxt  = 1'b1;
                    w_bit_nxt = w_scaled[31];
                end
            end
            ST_TXFER: begin
                if (!w_last) begin
                    w_tx_nxt  = 1'b1;
                    w_bit_nxt = r_shift[31];
                end else if (!w_end_led) begin
                    w_tx_nxt  = 1'b1;
                    w_bit_nxt = r_shift[30];
                end else if (w_more && w_next_avail) begin
                    w_tx_nxt  = 1'b1;
                    w_bit_nxt = w_next_word[31];
                end else begin
                    w_pz_nxt = 1'b1;
                end
            end
            ST_PAUSE: w_pz_nxt = !w_pause_last;
            default: ;
        endcase
    end

    pixel_bit_timer #(
        .DATA_TICKS (DATA_TICKS),
        .T0H        (T0H),
        .T1H        (T1H),
        .TW         (c_TW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_tx_nxt),
        .i_pause (w_pz_nxt),
        .i_bit   (w_bit_nxt),
        .o_tick  (w_tick),
        .o_out   (w_out),
        .o_last  (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_bright   <= 8'd0;
            r_shift    <= 32'd0;
            r_pf       <= 32'd0;
            r_pf_full  <= 1'b0;
            r_bit      <= 6'd0;
            r_acc      <= '0;
            r_led      <= '0;
            r_abort    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_bright  <= bright;
                        r_acc     <= '0;
                        r_led     <= '0;
                        r_pf_full <= 1'b0;
                        r_abort   <= 1'b0;
                        r_state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_acc) begin
                        r_shift <= w_scaled;
                        r_bit   <= 6'd0;
                        r_acc   <= r_acc + c_LW'(1);
                        r_state <= ST_TXFER;
                    end
                end
                ST_TXFER: begin
                    if (w_acc) begin
                        r_acc <= r_acc + c_LW'(1);
                        if (!w_end_led) begin
                            r_pf      <= w_scaled;
                            r_pf_full <= 1'b1;
                        end
                    end
                    if (w_last) begin
                        if (!w_end_led) begin
                            r_shift <= {r_shift[30:0], 1'b0};
                            r_bit   <= r_bit + 6'd1;
                        end else if (w_more && w_next_avail) begin
                            r_shift   <= w_next_word;
                            r_bit     <= 6'd0;
                            r_led     <= r_led + c_LW'(1);
                            r_pf_full <= 1'b0;
                        end else begin
                            r_state   <= ST_PAUSE;
                            r_pf_full <= 1'b0;
                            if (w_more) begin
                                r_underrun <= 1'b1;
                                r_abort    <= 1'b1;
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (w_pause_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (r_state != ST_IDLE) && !w_pause_last;
    assign done     = w_pause_last && !r_abort;
    assign underrun = r_underrun;
    assign out      = w_out;

endmodule

`default_nettype wire

// File: tb/tb_pixel_stream.sv
//==============================================================================
// Module      : tb_pixel_stream
// Description : Randomized self-checking bench for pixel_stream (GRB and GRBW builds).
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pixel_stream;

    localparam int DT    = 25;
    localparam int T0    = 6;
    localparam int T1    = 12;
    localparam int PT    = 1600;
    localparam int LEDS0 = 3;
    localparam int LEDS1 = 2;

    logic        clk = 1'b0;
    logic [1:0]  rst, st, pv, pr, bz, dn, ur, ot;
    logic [7:0]  br [2];
    logic [31:0] pd [2];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pixel_stream #(
        .DATA_TICKS(DT), .T0H(T0), .T1H(T1), .PAUSE_TICKS(PT), .LEDS(LEDS0), .WHITE(0)
    ) u_dut0 (
        .clk(clk), .rst(rst[0]), .start(st[0]), .bright(br[0]), .pix_valid(pv[0]),
        .pix_ready(pr[0]), .pix_data(pd[0]), .busy(bz[0]), .done(dn[0]),
        .underrun(ur[0]), .out(ot[0])
    );

    pixel_stream #(
        .DATA_TICKS(DT), .T0H(T0), .T1H(T1), .PAUSE_TICKS(PT), .LEDS(LEDS1), .WHITE(1)
    ) u_dut1 (
        .clk(clk), .rst(rst[1]), .start(st[1]), .bright(br[1]), .pix_valid(pv[1]),
        .pix_ready(pr[1]), .pix_data(pd[1]), .busy(bz[1]), .done(dn[1]),
        .underrun(ur[1]), .out(ot[1])
    );

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_scale(input logic [7:0] c, input int b);
        int v;
        v = (int'(c) * (b + 1)) / 256;
        return v[7:0];
    endfunction

    // Expected brightness-scaled word; the W byte is zero when not transmitted.
    function automatic logic [31:0] ref_word(input logic [31:0] w, input int b, input int white);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = ref_scale(w[8*k +: 8], b);
        if (white == 0) r[7:0] = 8'h00;
        return r;
    endfunction

    task automatic run_frame(input int d, input int b, input int n_sup, input int gapmax,
                             input bit use_fix, input logic [31:0] fix, input bit mid_start);
        int          leds, white, bits, nsent, len, limit, r0, fr, mis, ndn, idn, nur, iur;
        bit          und, over;
        logic [31:0] px [$];
        bit          q_out [$];
        bit          q_dn [$];
        bit          q_ur [$];
        bit          q_bz [$];
        bit          q_rd [$];
        int          acc [$];
        leds  = (d == 0) ? LEDS0 : LEDS1;
        white = d;
        bits  = 24 + 8 * white;
        nsent = (n_sup < leds) ? n_sup : leds;
        und   = (n_sup < leds);
        len   = nsent * bits * DT + PT;
        limit = leds * bits * DT + PT + 400;
        over  = 1'b0;
        for (int k = 0; k < n_sup; k++) px.push_back(use_fix ? fix : 32'($urandom()));

        @(posedge clk); #1;
        st[d] = 1'b1;
        br[d] = b[7:0];
        @(negedge clk);
        check_val("pre_busy", bz[d], 0);
        @(posedge clk); #1;
        st[d] = 1'b0;
        br[d] = 8'($urandom());

        fork
            begin
                for (int k = 0; k < n_sup && !over; k++) begin
                    int g;
                    g = $urandom_range(0, gapmax);
                    pv[d] = 1'b0;
                    for (int j = 0; j < g && !over; j++) begin @(posedge clk); #1; end
                    pv[d] = 1'b1;
                    pd[d] = px[k];
                    while (!pr[d] && !over) begin @(posedge clk); #1; end
                    @(posedge clk); #1;
                end
                pv[d] = 1'b0;
                pd[d] = 32'($urandom());
            end
            begin
                if (mid_start) begin
                    repeat (500) begin @(posedge clk); #1; end
                    st[d] = 1'b1;
                    @(posedge clk); #1;
                    st[d] = 1'b0;
                end
            end
            begin
                int  c;
                bit  fin;
                c   = 0;
                fin = 1'b0;
                while (!fin && c < limit) begin
                    @(negedge clk);
                    q_out.push_back(ot[d]);
                    q_dn.push_back(dn[d]);
                    q_ur.push_back(ur[d]);
                    q_bz.push_back(bz[d]);
                    q_rd.push_back(pr[d]);
                    if (pv[d] && pr[d]) acc.push_back(c);
                    if (c > 0 && !bz[d]) fin = 1'b1;
                    c++;
                end
                over = 1'b1;
                check_val("term", fin, 1);
            end
        join

        check_val("busy_n1", q_bz[0], 1);
        check_val("rdy_n1", q_rd[0], 1);
        check_val("n_acc", acc.size(), nsent);
        if (acc.size() > 0) begin
            r0 = acc[0] + 1;
            fr = -1;
            for (int i = 0; i < q_out.size(); i++) if (q_out[i] && fr < 0) fr = i;
            check_val("rise", fr, r0);

            mis = 0;
            for (int i = 0; i < len; i++) begin
                bit e;
                e = 1'b0;
                if (i < nsent * bits * DT) begin
                    int          led, bp, t;
                    logic [31:0] w;
                    led = i / (bits * DT);
                    bp  = (i % (bits * DT)) / DT;
                    t   = i % DT;
                    w   = ref_word(px[led], b, white);
                    e   = (t < (w[31 - bp] ? T1 : T0));
                end
                if (r0 + i >= q_out.size()) mis++;
                else if (q_out[r0 + i] != e) mis++;
            end
            check_val("wave", mis, 0);

            for (int led = 0; led < nsent; led++) begin
                logic [31:0] dec;
                dec = 32'd0;
                for (int bp = 0; bp < bits; bp++) begin
                    int cnt;
                    cnt = 0;
                    for (int t = 0; t < DT; t++) begin
                        int idx;
                        idx = r0 + (led * bits + bp) * DT + t;
                        if (idx < q_out.size() && q_out[idx]) cnt++;
                    end
                    dec[31 - bp] = (cnt > (T0 + T1) / 2);
                end
                check_val($sformatf("led%0d", led), dec, ref_word(px[led], b, white));
            end

            check_val("flen", q_bz.size() - 1, r0 + len - 1);
            ndn = 0; idn = -1; nur = 0; iur = -1;
            for (int i = 0; i < q_dn.size(); i++) begin
                if (q_dn[i]) begin ndn++; idn = i; end
                if (q_ur[i]) begin nur++; iur = i; end
            end
            check_val("done_n", ndn, und ? 0 : 1);
            if (!und) check_val("done_at", idn, r0 + len - 1);
            check_val("under_n", nur, und ? 1 : 0);
            if (und) check_val("under_at", iur, r0 + nsent * bits * DT);
        end
    endtask

    task automatic reset_mid(input int d);
        int g;
        g = 0;
        @(posedge clk); #1;
        pd[d] = 32'hFFFF_FFFF;
        pv[d] = 1'b1;
        st[d] = 1'b1;
        br[d] = 8'hFF;
        @(posedge clk); #1;
        st[d] = 1'b0;
        repeat (60) begin @(posedge clk); #1; end
        while (!ot[d] && g < 100) begin @(posedge clk); #1; g++; end
        check_val("rst_pre_out", ot[d], 1);
        rst[d] = 1'b1;
        pv[d]  = 1'b0;
        @(posedge clk); #1;
        rst[d] = 1'b0;
        @(negedge clk);
        check_val("rst_out", ot[d], 0);
        check_val("rst_busy", bz[d], 0);
        check_val("rst_rdy", pr[d], 0);
        check_val("rst_done", dn[d], 0);
        check_val("rst_under", ur[d], 0);
    endtask

    initial begin
        rst = 2'b11; st = 2'b00; pv = 2'b00;
        br[0] = 8'd0; br[1] = 8'd0; pd[0] = 32'd0; pd[1] = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 2'b00;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_val("reset_out", ot[d], 0);
            check_val("reset_busy", bz[d], 0);
            check_val("reset_rdy", pr[d], 0);
            check_val("reset_done", dn[d], 0);
            check_val("reset_under", ur[d], 0);
        end

        run_frame(0, 255, 3, 0, 1'b1, 32'hFF00_8000, 1'b0);
        run_frame(0, 127, 4, 0, 1'b1, 32'hC8C8_C800, 1'b0);
        run_frame(1, 255, 2, 0, 1'b1, 32'h0000_00FF, 1'b0);
        run_frame(0, 200, 2, 2, 1'b0, 32'd0, 1'b0);
        run_frame(0, 90, 3, 3, 1'b0, 32'd0, 1'b1);
        run_frame(0, 255, 3, 0, 1'b0, 32'd0, 1'b0);
        reset_mid(0);
        run_frame(0, 255, 3, 1, 1'b0, 32'd0, 1'b0);
        for (int r = 0; r < 3; r++) begin
            run_frame(0, $urandom_range(0, 255), $urandom_range(1, LEDS0 + 1), 4, 1'b0, 32'd0, 1'b0);
            run_frame(1, $urandom_range(0, 255), $urandom_range(1, LEDS1 + 1), 4, 1'b0, 32'd0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
